// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Brief    : Register-file write port arbiter (ALU priority, buffered LSU path)
//            with a pending-destination scoreboard and decode hazard flag.
// Revision : 1.0
// ============================================================================
module regfile_writeback #(
  parameter int DW         = 32,
  parameter int WORDS      = 32,
  parameter int ADDRW      = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid_i,
  input  logic [ADDRW-1:0] alu_addr_i,
  input  logic [DW-1:0]    alu_data_i,
  input  logic             lsu_valid_i,
  output logic             lsu_ready_o,
  input  logic [ADDRW-1:0] lsu_addr_i,
  input  logic [DW-1:0]    lsu_data_i,
  input  logic             issue_en_i,
  input  logic [ADDRW-1:0] issue_addr_i,
  input  logic [ADDRW-1:0] rs1_addr_i,
  input  logic [ADDRW-1:0] rs2_addr_i,
  output logic             hazard_o,
  output logic             wr_en_o,
  output logic [ADDRW-1:0] wr_addr_o,
  output logic [DW-1:0]    wr_data_o
);

  localparam int              CW         = $clog2(FIFO_DEPTH + 1);
  localparam int              PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]   C_DEPTH    = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   C_LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [ADDRW-1:0] C_X0      = '0;

  logic [ADDRW-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DW-1:0]    r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WORDS-1:0] r_pending;
  logic             r_wr_en;
  logic [ADDRW-1:0] r_wr_addr;
  logic [DW-1:0]    r_wr_data;

  logic             w_alu_req;
  logic             w_push;
  logic             w_pop;
  logic [ADDRW-1:0] w_head_addr;
  logic [DW-1:0]    w_head_data;
  logic [WORDS-1:0] w_pending_nxt;
  logic             w_hz_rs1;
  logic             w_hz_rs2;

  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Ready is forced low during reset; when full it stays low even on a pop edge.
  assign lsu_ready_o = rst & (r_count < C_DEPTH);
  assign w_alu_req   = alu_valid_i & (alu_addr_i != C_X0);
  assign w_push      = lsu_valid_i & lsu_ready_o & (lsu_addr_i != C_X0);
  assign w_pop       = ~w_alu_req & (r_count != '0);
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop)
      w_pending_nxt[w_head_addr] = 1'b0;
    // Issue applied last so a same-edge set beats the clear.
    if (issue_en_i && (issue_addr_i != C_X0))
      w_pending_nxt[issue_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= lsu_addr_i;
      r_fifo_data[r_wr_ptr] <= lsu_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push)
        r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_pop)
        r_rd_ptr <= f_next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_wr_en <= w_alu_req | w_pop;
      if (w_alu_req) begin
        r_wr_addr <= alu_addr_i;
        r_wr_data <= alu_data_i;
      end else if (w_pop) begin
        r_wr_addr <= w_head_addr;
        r_wr_data <= w_head_data;
      end
    end
  end

  // The register file has no write-through, so an in-flight write is still a hazard.
  assign w_hz_rs1 = r_pending[rs1_addr_i] |
                    (r_wr_en & (r_wr_addr == rs1_addr_i) & (rs1_addr_i != C_X0));
  assign w_hz_rs2 = r_pending[rs2_addr_i] |
                    (r_wr_en & (r_wr_addr == rs2_addr_i) & (rs2_addr_i != C_X0));
  assign hazard_o = w_hz_rs1 | w_hz_rs2;

  assign wr_en_o   = r_wr_en;
  assign wr_addr_o = r_wr_addr;
  assign wr_data_o = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Brief    : Directed self-checking bench for regfile_writeback.
// Revision : 1.0
// ============================================================================
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        issue_en_i;
  logic [4:0]  issue_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        hazard_o;
  logic        wr_en_o;
  logic [4:0]  wr_addr_o;
  logic [31:0] wr_data_o;

  int n_checks = 0;
  int n_errors = 0;

  regfile_writeback dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid_i  (alu_valid_i),
    .alu_addr_i   (alu_addr_i),
    .alu_data_i   (alu_data_i),
    .lsu_valid_i  (lsu_valid_i),
    .lsu_ready_o  (lsu_ready_o),
    .lsu_addr_i   (lsu_addr_i),
    .lsu_data_i   (lsu_data_i),
    .issue_en_i   (issue_en_i),
    .issue_addr_i (issue_addr_i),
    .rs1_addr_i   (rs1_addr_i),
    .rs2_addr_i   (rs2_addr_i),
    .hazard_o     (hazard_o),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o)
  );

  always #5 clk = ~clk;

  // Upstream contract monitor: outstanding = issued but result not yet returned.
  logic [31:0] r_outst;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_outst <= '0;
    end else begin
      if (issue_en_i && issue_addr_i != 5'd0)
        assert (!r_outst[issue_addr_i]) else $error("contract: issue to outstanding reg %0d", issue_addr_i);
      if (alu_valid_i && alu_addr_i != 5'd0)
        assert (!r_outst[alu_addr_i]) else $error("contract: alu write to outstanding reg %0d", alu_addr_i);
      if (lsu_valid_i && lsu_ready_o && lsu_addr_i != 5'd0)
        assert (r_outst[lsu_addr_i]) else $error("contract: lsu result for idle reg %0d", lsu_addr_i);
      for (int i = 1; i < 32; i++) begin
        if (issue_en_i && issue_addr_i == 5'(i))
          r_outst[i] <= 1'b1;
        else if (lsu_valid_i && lsu_ready_o && lsu_addr_i == 5'(i))
          r_outst[i] <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [4:0] addr,
                          input logic [31:0] data);
    check({tag, ".en"},   32'(wr_en_o),   32'(en));
    check({tag, ".addr"}, 32'(wr_addr_o), 32'(addr));
    check({tag, ".data"}, wr_data_o,      data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_en_i   = 1'b1;
    issue_addr_i = a;
    tick();
    issue_en_i   = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid_i = 0; alu_addr_i = 0; alu_data_i = 0;
    lsu_valid_i = 0; lsu_addr_i = 0; lsu_data_i = 0;
    issue_en_i = 0; issue_addr_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;

    // Reset state
    #2;
    check_wr("reset", 1'b0, 5'd0, 32'd0);
    check("reset.ready", 32'(lsu_ready_o), 32'd0);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("post_reset.ready", 32'(lsu_ready_o), 32'd1);
    check("post_reset.hazard", 32'(hazard_o), 32'd0);

    // ALU only
    alu_valid_i = 1; alu_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    tick();
    alu_valid_i = 0; rs1_addr_i = 5'd5;
    #1;
    check_wr("alu.n1", 1'b1, 5'd5, 32'hDEADBEEF);
    check("alu.inflight_hazard", 32'(hazard_o), 32'd1);
    tick();
    check_wr("alu.n2", 1'b0, 5'd5, 32'hDEADBEEF);
    check("alu.hazard_clear", 32'(hazard_o), 32'd0);
    alu_valid_i = 1; alu_addr_i = 5'd0; alu_data_i = 32'h55;
    tick();
    alu_valid_i = 0;
    check_wr("alu.x0", 1'b0, 5'd5, 32'hDEADBEEF);

    // LSU path with scoreboard
    issue(5'd7);
    rs1_addr_i = 5'd7;
    #1;
    check("lsu.hazard_issued", 32'(hazard_o), 32'd1);
    tick(); tick();
    check("lsu.hazard_wait", 32'(hazard_o), 32'd1);
    lsu_valid_i = 1; lsu_addr_i = 5'd7; lsu_data_i = 32'h1234;
    #1;
    check("lsu.ready", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 0;
    check_wr("lsu.n1", 1'b0, 5'd5, 32'hDEADBEEF);
    check("lsu.hazard_n1", 32'(hazard_o), 32'd1);
    tick();
    check_wr("lsu.n2", 1'b1, 5'd7, 32'h1234);
    check("lsu.hazard_n2", 32'(hazard_o), 32'd1);
    tick();
    check_wr("lsu.n3", 1'b0, 5'd7, 32'h1234);
    check("lsu.hazard_n3", 32'(hazard_o), 32'd0);
    rs1_addr_i = 5'd0;

    // Contention and backpressure
    issue(5'd8); issue(5'd9); issue(5'd10);
    alu_valid_i = 1; alu_addr_i = 5'd1; alu_data_i = 32'h101;
    lsu_valid_i = 1; lsu_addr_i = 5'd8; lsu_data_i = 32'hA1;
    #1;
    check("cont.ready0", 32'(lsu_ready_o), 32'd1);
    tick();
    check_wr("cont.e1", 1'b1, 5'd1, 32'h101);
    alu_addr_i = 5'd2; alu_data_i = 32'h102;
    lsu_addr_i = 5'd9; lsu_data_i = 32'hA2;
    #1;
    check("cont.ready1", 32'(lsu_ready_o), 32'd1);
    tick();
    check_wr("cont.e2", 1'b1, 5'd2, 32'h102);
    alu_addr_i = 5'd3; alu_data_i = 32'h103;
    lsu_addr_i = 5'd10; lsu_data_i = 32'hA3;
    #1;
    check("cont.ready_full", 32'(lsu_ready_o), 32'd0);
    tick();
    check_wr("cont.e3", 1'b1, 5'd3, 32'h103);
    alu_addr_i = 5'd4; alu_data_i = 32'h104;
    tick();
    check_wr("cont.e4", 1'b1, 5'd4, 32'h104);
    check("cont.ready_full2", 32'(lsu_ready_o), 32'd0);
    alu_valid_i = 0;
    tick();
    check_wr("cont.e5", 1'b1, 5'd8, 32'hA1);
    check("cont.ready_back", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 0;
    check_wr("cont.e6", 1'b1, 5'd9, 32'hA2);
    rs2_addr_i = 5'd10;
    #1;
    check("cont.hazard10", 32'(hazard_o), 32'd1);
    tick();
    check_wr("cont.e7", 1'b1, 5'd10, 32'hA3);
    tick();
    check_wr("cont.e8", 1'b0, 5'd10, 32'hA3);
    rs1_addr_i = 5'd8;
    #1;
    check("cont.hazard_done", 32'(hazard_o), 32'd0);
    rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;

    // Back-to-back LSU stream at count=1 across pointer wrap
    for (int i = 0; i < 16; i++) issue(5'(11 + i));
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        lsu_valid_i = 1; lsu_addr_i = 5'(11 + i); lsu_data_i = 32'(i);
        #1;
        check($sformatf("stream.ready%0d", i), 32'(lsu_ready_o), 32'd1);
      end else begin
        lsu_valid_i = 0;
      end
      tick();
      if (i >= 1)
        check_wr($sformatf("stream.w%0d", i - 1), 1'b1, 5'(10 + i), 32'(i - 1));
    end
    tick();
    check_wr("stream.idle", 1'b0, 5'd26, 32'd15);

    // x0 LSU result: handshake completes, nothing written
    lsu_valid_i = 1; lsu_addr_i = 5'd0; lsu_data_i = 32'h77;
    #1;
    check("x0.ready", 32'(lsu_ready_o), 32'd1);
    tick();
    lsu_valid_i = 0;
    check("x0.ready_after", 32'(lsu_ready_o), 32'd1);
    tick();
    check_wr("x0.nowrite1", 1'b0, 5'd26, 32'd15);
    tick();
    check_wr("x0.nowrite2", 1'b0, 5'd26, 32'd15);

    // Mid-stream asynchronous reset with a full buffer
    issue(5'd8); issue(5'd9);
    alu_valid_i = 1; alu_addr_i = 5'd1; alu_data_i = 32'h201;
    lsu_valid_i = 1; lsu_addr_i = 5'd8; lsu_data_i = 32'hB1;
    tick();
    lsu_addr_i = 5'd9; lsu_data_i = 32'hB2;
    tick();
    lsu_valid_i = 0;
    rs1_addr_i = 5'd8;
    #1;
    check("rst.full", 32'(lsu_ready_o), 32'd0);
    check("rst.hazard_before", 32'(hazard_o), 32'd1);
    check("rst.wr_before", 32'(wr_en_o), 32'd1);
    #1;
    rst = 1'b0;
    alu_valid_i = 0;
    #1;
    check("rst.wr_en_now", 32'(wr_en_o), 32'd0);
    check("rst.ready_now", 32'(lsu_ready_o), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rst.ready_after", 32'(lsu_ready_o), 32'd1);
    check("rst.hazard_after", 32'(hazard_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("rst.nostale%0d", i), 32'(wr_en_o), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side front end of the integer register file; sole driver of its single write port (wr_en / wr_addr / wr_data).
- Merges two producers:
  - single-cycle ALU results, with no backpressure;
  - multi-cycle LSU/MUL-DIV results, via a valid/ready handshake and a 2-entry buffer.
- Holds a pending-destination scoreboard for long-latency ops and flags read-after-write hazards to decode.

Parameters:
DW, 32, data width
WORDS, 32, number of architectural registers
ADDRW, 5, register address width
FIFO_DEPTH, 2, LSU result buffer entries

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
alu_valid_i  in  1  ALU result valid this cycle (no backpressure)
alu_addr_i  in  ADDRW  ALU destination register
alu_data_i  in  DW  ALU result
lsu_valid_i  in  1  long-latency result valid
lsu_ready_o  out  1  buffer can accept
lsu_addr_i  in  ADDRW  long-latency destination
lsu_data_i  in  DW  long-latency result
issue_en_i  in  1  long-latency op issued this cycle
issue_addr_i  in  ADDRW  its destination (scoreboard set)
rs1_addr_i  in  ADDRW  decode source 1
rs2_addr_i  in  ADDRW  decode source 2
hazard_o  out  1  a decode source is not yet readable
wr_en_o  out  1  register file write enable (registered)
wr_addr_o  out  ADDRW  register file write address (registered)
wr_data_o  out  DW  register file write data (registered)

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied (count=0); pending[] all 0;
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0;
  - lsu_ready_o=0 while rst=0.
- After reset release: lsu_ready_o = (count < FIFO_DEPTH), combinational from count.
- Handshake: LSU transfer occurs on an edge with lsu_valid_i & lsu_ready_o. The producer holds addr/data stable while valid & !ready.
- x0 handling:
  - alu_valid_i with alu_addr_i=0 is treated as no request.
  - LSU transfer with lsu_addr_i=0 completes the handshake but is dropped (not pushed).
  - issue_addr_i=0 sets nothing.
- Arbitration, evaluated each edge:
  - ALU request present: output regs load ALU addr/data, wr_en_o=1 next cycle. ALU latency is 1 cycle.
  - Else FIFO non-empty: pop head into output regs, wr_en_o=1 next cycle.
  - Else: wr_en_o=0; addr/data hold their last value.
- LSU latency:
  - Minimum 2 cycles: accept edge, then pop edge, then wr_en_o high.
  - No FIFO bypass.
  - ALU has strict priority; LSU entries wait indefinitely.
- FIFO:
  - Circular buffer with separate rd/wr pointers that wrap modulo FIFO_DEPTH; order preserved.
  - Push and pop on the same edge are legal when 0<count<DEPTH: count unchanged.
  - When full, ready=0 even if a pop occurs that edge, so no same-edge refill.
- Scoreboard, pending[WORDS-1:0]:
  - Set on edge with issue_en_i & issue_addr_i!=0.
  - Cleared on the edge the matching entry is popped to the output regs.
  - Same-edge set and clear of the same index: set wins.
- hazard_o (combinational), for rs in {rs1, rs2}:
  - pending[rs], or
  - wr_en_o & wr_addr_o==rs & rs!=0.
  - Register file reads have no internal write-through.
- Upstream contract, checked by bench assertions, not handled internally:
  - no issue to, or ALU write to, a register whose pending bit is set;
  - LSU results only for registers pending.
- Reset mid-operation: buffered entries and pending bits are discarded; no write is issued after reset release until a new request arrives.

Test Plan:
- ALU only: alu_valid_i=1, addr=5, data=0xDEADBEEF at edge N → wr_en_o=1, wr_addr_o=5, wr_data_o=0xDEADBEEF in cycle N+1, then wr_en_o=0; alu addr=0 → wr_en_o stays 0.
- LSU path with scoreboard:
  - Stimulus: issue_en_i addr=7, then rs1_addr_i=7; later LSU result addr=7, data=0x1234.
  - After the issue edge, rs1_addr_i=7 → hazard_o=1.
  - LSU accepted edge N → wr_en_o=1, addr 7, data 0x1234 at N+2.
  - hazard_o stays 1 through that cycle, then 0.
- Contention and backpressure:
  - ALU valid every cycle for 4 cycles while LSU pushes 0xA1, 0xA2, 0xA3 to regs 8, 9, 10.
  - lsu_ready_o drops to 0 after two accepts.
  - After ALU stops: writes 0xA1 then 0xA2 on consecutive cycles, ready returns to 1, then 0xA3 follows; order preserved.
- Simultaneous push/pop at count=1 with ALU idle → count stays 1, one write per cycle, no loss across pointer wrap (16 back-to-back results, values 0..15).
- x0 LSU result: valid=1, addr=0 → handshake completes, no write, count unchanged.
- Mid-stream reset:
  - Stimulus: FIFO holding 2 entries, pending[8]=1, rst pulsed low asynchronously between edges.
  - Immediately: wr_en_o=0, lsu_ready_o=0.
  - After release: ready=1, hazard_o=0 for rs1=8, and no stale writes ever appear.
